// File: rtl/mem_access_unit_if.sv
// Command, register-file and external byte-bus signals of the memory access unit.
// The unit itself connects through the master modport; the command source/bus/register side uses slave.
interface mem_access_unit_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_store;
    logic        cmd_byte;
    logic [3:0]  cmd_reg;
    logic [15:0] cmd_addr;
    logic [3:0]  reg_index;
    logic [15:0] reg_load;
    logic        reg_load_en;
    logic [15:0] reg_store;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ack;
    logic        done;
    logic        err;

    modport master (
        input  cmd_valid, cmd_store, cmd_byte, cmd_reg, cmd_addr, reg_store, bus_rdata, bus_ack,
        output cmd_ready, reg_index, reg_load, reg_load_en, bus_req, bus_we, bus_addr, bus_wdata,
               done, err
    );

    modport slave (
        output cmd_valid, cmd_store, cmd_byte, cmd_reg, cmd_addr, reg_store, bus_rdata, bus_ack,
        input  cmd_ready, reg_index, reg_load, reg_load_en, bus_req, bus_we, bus_addr, bus_wdata,
               done, err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-side master of the register file: moves one byte or one little-endian 16-bit word
// between a register and the 8-bit external bus, one command at a time. All outputs are registered.
module mem_access_unit #(
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.master ifc
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SNAP = 3'd1,
        S_LO   = 3'd2,
        S_HI   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        store_q, store_d;
    logic        byte_q, byte_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] timer_q, timer_d;
    logic        abort_q, abort_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic [3:0]  reg_index_q, reg_index_d;
    logic [15:0] reg_load_q, reg_load_d;
    logic        reg_load_en_q, reg_load_en_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic [7:0]  bus_wdata_q, bus_wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ack_s;
    logic        timeout_s;

    // Next-state, datapath and next-output logic; outputs are derived from the upcoming state
    // so that every port comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        byte_d      = byte_q;
        addr_d      = addr_q;
        data_d      = data_q;
        abort_d     = abort_q;
        reg_index_d = reg_index_q;
        reg_load_d  = reg_load_q;
        ack_s       = bus_req_q && ifc.bus_ack;
        timeout_s   = (TIMEOUT != 32'sd0) && (timer_q == TMO_LAST);

        case (state_q)
            S_IDLE: begin
                if (ifc.cmd_valid) begin
                    store_d     = ifc.cmd_store;
                    byte_d      = ifc.cmd_byte;
                    addr_d      = ifc.cmd_addr;
                    reg_index_d = ifc.cmd_reg;
                    data_d      = 16'h0000;
                    abort_d     = 1'b0;
                    state_d     = ifc.cmd_store ? S_SNAP : S_LO;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SNAP: begin
                data_d  = ifc.reg_store;
                state_d = S_LO;
            end
            S_LO: begin
                if (ack_s) begin
                    if (!store_q) begin
                        data_d[7:0] = ifc.bus_rdata;
                    end else begin
                        data_d = data_q;
                    end
                    state_d = byte_q ? S_RESP : S_HI;
                end else if (timeout_s) begin
                    abort_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_LO;
                end
            end
            S_HI: begin
                if (ack_s) begin
                    if (!store_q) begin
                        data_d[15:8] = ifc.bus_rdata;
                    end else begin
                        data_d = data_q;
                    end
                    state_d = S_RESP;
                end else if (timeout_s) begin
                    abort_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_HI;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The wait timer restarts per byte: on entering LO/HI and on every completed byte.
        if ((state_d != state_q) || ack_s) begin
            timer_d = 16'h0000;
        end else if (bus_req_q) begin
            timer_d = timer_q + 16'd1;
        end else begin
            timer_d = timer_q;
        end

        cmd_ready_d = (state_d == S_IDLE);
        bus_req_d   = (state_d == S_LO) || (state_d == S_HI);
        if (state_d == S_LO) begin
            bus_we_d    = store_d;
            bus_addr_d  = addr_d;
            bus_wdata_d = data_d[7:0];
        end else if (state_d == S_HI) begin
            bus_we_d    = store_d;
            bus_addr_d  = addr_d + 16'd1;
            bus_wdata_d = data_d[15:8];
        end else begin
            bus_we_d    = 1'b0;
            bus_addr_d  = 16'h0000;
            bus_wdata_d = 8'h00;
        end

        done_d        = (state_d == S_RESP);
        err_d         = (state_d == S_RESP) && abort_d;
        reg_load_en_d = (state_d == S_RESP) && !abort_d && !store_d;
        if (reg_load_en_d) begin
            reg_load_d = byte_d ? {8'h00, data_d[7:0]} : data_d;
        end else begin
            reg_load_d = reg_load_q;
        end
    end

    // State, datapath and output registers; reset aborts any command in flight at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            store_q       <= 1'b0;
            byte_q        <= 1'b0;
            addr_q        <= 16'h0000;
            data_q        <= 16'h0000;
            timer_q       <= 16'h0000;
            abort_q       <= 1'b0;
            cmd_ready_q   <= 1'b1;
            reg_index_q   <= 4'h0;
            reg_load_q    <= 16'h0000;
            reg_load_en_q <= 1'b0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 16'h0000;
            bus_wdata_q   <= 8'h00;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            store_q       <= store_d;
            byte_q        <= byte_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            timer_q       <= timer_d;
            abort_q       <= abort_d;
            cmd_ready_q   <= cmd_ready_d;
            reg_index_q   <= reg_index_d;
            reg_load_q    <= reg_load_d;
            reg_load_en_q <= reg_load_en_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign ifc.cmd_ready   = cmd_ready_q;
    assign ifc.reg_index   = reg_index_q;
    assign ifc.reg_load    = reg_load_q;
    assign ifc.reg_load_en = reg_load_en_q;
    assign ifc.bus_req     = bus_req_q;
    assign ifc.bus_we      = bus_we_q;
    assign ifc.bus_addr    = bus_addr_q;
    assign ifc.bus_wdata   = bus_wdata_q;
    assign ifc.done        = done_q;
    assign ifc.err         = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT=4) with a byte-bus responder model
// that inserts a programmable number of wait cycles and logs every completed byte.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_access_unit_if ifc ();

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .ifc (ifc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus responder state: written by main (config) or by the responder (log) only.
    int          waits = 0;
    bit          noack = 1'b0;
    logic [7:0]  rd_bytes [64];
    int          log_n;
    int          wait_cnt;
    logic [15:0] log_addr  [64];
    logic        log_we    [64];
    logic [7:0]  log_wdata [64];

    initial begin
        ifc.bus_ack   = 1'b0;
        ifc.bus_rdata = 8'h00;
        log_n         = 0;
        wait_cnt      = 0;
        forever begin
            @(posedge clk);
            if (ifc.bus_req && ifc.bus_ack && !rst) begin
                if (log_n < 64) begin
                    log_addr[log_n]  = ifc.bus_addr;
                    log_we[log_n]    = ifc.bus_we;
                    log_wdata[log_n] = ifc.bus_wdata;
                end
                log_n++;
                wait_cnt = 0;
            end
            @(negedge clk);
            if (ifc.bus_req && !noack && (wait_cnt >= waits)) begin
                ifc.bus_ack   = 1'b1;
                ifc.bus_rdata = rd_bytes[log_n % 64];
            end else begin
                ifc.bus_ack   = 1'b0;
                ifc.bus_rdata = 8'h00;
                wait_cnt      = ifc.bus_req ? wait_cnt + 1 : 0;
            end
        end
    end

    int          base;
    int          res_lat;
    int          req_cycles;
    logic [3:0]  res_idx;
    logic [15:0] res_load;
    logic        res_len;
    logic        res_err;
    logic        saw_len;

    // Issue one command and follow it to its done pulse; res_lat is the spec-style latency
    // (done is the N-th edge after the accept edge).
    task automatic run_cmd(input logic st, input logic bt, input logic [3:0] r, input logic [15:0] a);
        int          j;
        bit          seen;
        logic        prev_req;
        logic [15:0] prev_addr;
        logic [7:0]  prev_wd;
        logic        prev_we;
        int          prev_log;
        @(negedge clk);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_store = st;
        ifc.cmd_byte  = bt;
        ifc.cmd_reg   = r;
        ifc.cmd_addr  = a;
        j = 0;
        while (!ifc.cmd_ready && j < 20) begin
            @(negedge clk);
            j++;
        end
        base = log_n;
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        j = 0; seen = 1'b0; saw_len = 1'b0; req_cycles = 0; res_lat = 0;
        prev_req = 1'b0; prev_addr = 16'h0000; prev_wd = 8'h00; prev_we = 1'b0; prev_log = log_n;
        while (!seen && j < 40) begin
            if (ifc.reg_load_en) saw_len = 1'b1;
            if (ifc.bus_req) begin
                req_cycles++;
                if (prev_req && (log_n == prev_log)) begin
                    check_eq("hold_addr", 32'(ifc.bus_addr), 32'(prev_addr));
                    check_eq("hold_wdata", 32'(ifc.bus_wdata), 32'(prev_wd));
                    check_eq("hold_we", 32'(ifc.bus_we), 32'(prev_we));
                end
            end
            prev_req = ifc.bus_req; prev_addr = ifc.bus_addr;
            prev_wd = ifc.bus_wdata; prev_we = ifc.bus_we; prev_log = log_n;
            if (ifc.done) begin
                seen     = 1'b1;
                res_lat  = j + 1;
                res_idx  = ifc.reg_index;
                res_load = ifc.reg_load;
                res_len  = ifc.reg_load_en;
                res_err  = ifc.err;
            end else begin
                @(negedge clk);
                j++;
            end
        end
        if (!seen) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int j;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_store = 1'b0;
        ifc.cmd_byte  = 1'b0;
        ifc.cmd_reg   = 4'h0;
        ifc.cmd_addr  = 16'h0000;
        ifc.reg_store = 16'h0000;
        for (int i = 0; i < 64; i++) rd_bytes[i] = 8'h00;
        repeat (2) @(negedge clk);

        check_eq("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
        check_eq("rst_bus_req", 32'(ifc.bus_req), 32'd0);
        check_eq("rst_bus_addr", 32'(ifc.bus_addr), 32'd0);
        check_eq("rst_reg_index", 32'(ifc.reg_index), 32'd0);
        check_eq("rst_reg_load_en", 32'(ifc.reg_load_en), 32'd0);
        check_eq("rst_done_err", 32'({ifc.done, ifc.err}), 32'd0);
        rst = 1'b0;

        // Word load r5 @0x1234, zero wait states.
        rd_bytes[log_n] = 8'hCD; rd_bytes[log_n + 1] = 8'hAB; waits = 0;
        run_cmd(1'b0, 1'b0, 4'd5, 16'h1234);
        check_eq("t1_latency", 32'(res_lat), 32'd3);
        check_eq("t1_txns", 32'(log_n - base), 32'd2);
        check_eq("t1_addr0", 32'(log_addr[base]), 32'h1234);
        check_eq("t1_addr1", 32'(log_addr[base + 1]), 32'h1235);
        check_eq("t1_we", 32'(log_we[base]), 32'd0);
        check_eq("t1_index", 32'(res_idx), 32'd5);
        check_eq("t1_load", 32'(res_load), 32'hABCD);
        check_eq("t1_load_en", 32'({res_len, res_err}), 32'b10);

        // Word store r3=0xBEEF @0x0100, two wait cycles per byte.
        ifc.reg_store = 16'hBEEF; waits = 2;
        run_cmd(1'b1, 1'b0, 4'd3, 16'h0100);
        check_eq("t2_latency", 32'(res_lat), 32'd8);
        check_eq("t2_txns", 32'(log_n - base), 32'd2);
        check_eq("t2_addr0", 32'(log_addr[base]), 32'h0100);
        check_eq("t2_wdata0", 32'(log_wdata[base]), 32'hEF);
        check_eq("t2_addr1", 32'(log_addr[base + 1]), 32'h0101);
        check_eq("t2_wdata1", 32'(log_wdata[base + 1]), 32'hBE);
        check_eq("t2_we", 32'({log_we[base], log_we[base + 1]}), 32'b11);
        check_eq("t2_req_cycles", 32'(req_cycles), 32'd6);
        check_eq("t2_no_load_en", 32'({saw_len, res_err}), 32'd0);
        check_eq("t2_index", 32'(res_idx), 32'd3);

        // Byte load r0 @0xFFFF: single transaction, zero-extended.
        rd_bytes[log_n] = 8'h80; waits = 0;
        run_cmd(1'b0, 1'b1, 4'd0, 16'hFFFF);
        check_eq("t3_latency", 32'(res_lat), 32'd2);
        check_eq("t3_txns", 32'(log_n - base), 32'd1);
        check_eq("t3_addr", 32'(log_addr[base]), 32'hFFFF);
        check_eq("t3_index", 32'(res_idx), 32'd0);
        check_eq("t3_load", 32'(res_load), 32'h0080);
        check_eq("t3_load_en", 32'(res_len), 32'd1);

        // Byte store r7=0x1357 @0x0042 sends only the low byte.
        ifc.reg_store = 16'h1357;
        run_cmd(1'b1, 1'b1, 4'd7, 16'h0042);
        check_eq("bs_latency", 32'(res_lat), 32'd3);
        check_eq("bs_txns", 32'(log_n - base), 32'd1);
        check_eq("bs_addr", 32'(log_addr[base]), 32'h0042);
        check_eq("bs_wdata", 32'(log_wdata[base]), 32'h57);
        check_eq("bs_no_load_en", 32'(saw_len), 32'd0);

        // Word load @0xFFFF wraps the high-byte address to 0x0000.
        rd_bytes[log_n] = 8'h34; rd_bytes[log_n + 1] = 8'h12;
        run_cmd(1'b0, 1'b0, 4'd2, 16'hFFFF);
        check_eq("t4_addr0", 32'(log_addr[base]), 32'hFFFF);
        check_eq("t4_addr1", 32'(log_addr[base + 1]), 32'h0000);
        check_eq("t4_load", 32'(res_load), 32'h1234);
        check_eq("t4_latency", 32'(res_lat), 32'd3);

        // No ack: abort after four request cycles.
        noack = 1'b1;
        run_cmd(1'b0, 1'b0, 4'd6, 16'h0300);
        check_eq("t5_req_cycles", 32'(req_cycles), 32'd4);
        check_eq("t5_latency", 32'(res_lat), 32'd5);
        check_eq("t5_err", 32'(res_err), 32'd1);
        check_eq("t5_no_load_en", 32'({res_len, saw_len}), 32'd0);
        check_eq("t5_txns", 32'(log_n - base), 32'd0);
        // Present the next command during RESP; it must be taken in the following IDLE cycle.
        noack = 1'b0; rd_bytes[log_n] = 8'h77;
        ifc.cmd_valid = 1'b1; ifc.cmd_store = 1'b0; ifc.cmd_byte = 1'b1;
        ifc.cmd_reg = 4'd1; ifc.cmd_addr = 16'h0010;
        @(negedge clk);
        check_eq("t5_idle_ready", 32'(ifc.cmd_ready), 32'd1);
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        check_eq("t5_next_req", 32'({ifc.bus_req, ifc.cmd_ready}), 32'b10);
        j = 0;
        while (!ifc.done && j < 10) begin
            @(negedge clk);
            j++;
        end
        check_eq("t5_next_load", 32'(ifc.reg_load), 32'h0077);

        // Reset during HI of a word load, then a fresh load.
        rd_bytes[log_n] = 8'h11; rd_bytes[log_n + 1] = 8'h22; waits = 3;
        @(negedge clk);
        ifc.cmd_valid = 1'b1; ifc.cmd_byte = 1'b0; ifc.cmd_reg = 4'd9; ifc.cmd_addr = 16'h2000;
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        j = 0;
        while (!(ifc.bus_req && ifc.bus_addr == 16'h2001) && j < 20) begin
            @(negedge clk);
            j++;
        end
        check_eq("t6_reached_hi", 32'(ifc.bus_addr), 32'h2001);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_req_async", 32'(ifc.bus_req), 32'd0);
        check_eq("t6_no_load_en", 32'({ifc.reg_load_en, ifc.done}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("t6_ready", 32'(ifc.cmd_ready), 32'd1);
        rd_bytes[log_n] = 8'h5A; rd_bytes[log_n + 1] = 8'hA5; waits = 0;
        run_cmd(1'b0, 1'b0, 4'd9, 16'h2000);
        check_eq("t6_latency", 32'(res_lat), 32'd3);
        check_eq("t6_load", 32'(res_load), 32'hA55A);
        check_eq("t6_index", 32'(res_idx), 32'd9);
        check_eq("t6_load_en", 32'(res_len), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
